isdu_lc3: RTL and testbench

- Instruction Sequence & Decode Unit for the LC-3 datapath.
- A Moore FSM that drives every load, gate, mux-select and memory-strobe signal.
- Sequences fetch, decode and execute, including issuing LD_CC/LD_BEN to the condition-code/branch-enable register and consuming its BEN output.
- Sits between the top-level switches (Run/Continue) and the datapath/SRAM interface.

---
 rtl/lc3_pkg.sv | 42 ++++
 rtl/isdu_lc3.sv | 140 ++++++++++++++
 tb/tb_isdu_lc3.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC-3 instruction sequencer: state names,
// opcode values and the mux/ALU select codes driven into the datapath.
package lc3_pkg;

  typedef enum logic [4:0] {
    HALTED, S_18, S_33, S_35, S_32,
    S_01, S_05, S_09, S_00, S_22, S_12,
    S_04, S_21, S_20,
    S_06, S_25, S_27, S_07, S_23, S_16,
    PAUSE_IR1, PAUSE_IR2
  } state_t;

  localparam logic [3:0] OP_BR            = 4'b0000;
  localparam logic [3:0] OP_ADD           = 4'b0001;
  localparam logic [3:0] OP_JSR           = 4'b0100;
  localparam logic [3:0] OP_AND           = 4'b0101;
  localparam logic [3:0] OP_LDR           = 4'b0110;
  localparam logic [3:0] OP_STR           = 4'b0111;
  localparam logic [3:0] OP_NOT           = 4'b1001;
  localparam logic [3:0] OP_JMP           = 4'b1100;
  localparam logic [3:0] OP_PAUSE_DEFAULT = 4'b1101;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  // States that hold a memory strobe for a counted number of cycles.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_33) || (s == S_25) || (s == S_16);
  endfunction

endpackage

// File: rtl/isdu_lc3.sv
// LC-3 instruction sequence and decode unit: Moore FSM producing every load,
// bus-gate, mux-select and memory-strobe control for the datapath.
module isdu_lc3
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT_CYCLES = 3,
  parameter logic [3:0]  OP_PAUSE        = OP_PAUSE_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [2:0] wait_cnt_reg, wait_cnt_next;
  logic       wait_done;

  assign wait_done = (wait_cnt_reg == 3'd0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= HALTED;
      wait_cnt_reg <= 3'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HALTED:    if (Run) state_next = S_18;
      S_18:      state_next = S_33;
      S_33:      if (wait_done) state_next = S_35;
      S_35:      state_next = S_32;
      S_32: begin
        if (Opcode == OP_PAUSE) begin
          state_next = PAUSE_IR1;
        end else begin
          case (Opcode)
            OP_ADD:  state_next = S_01;
            OP_AND:  state_next = S_05;
            OP_NOT:  state_next = S_09;
            OP_BR:   state_next = S_00;
            OP_JMP:  state_next = S_12;
            OP_JSR:  state_next = S_04;
            OP_LDR:  state_next = S_06;
            OP_STR:  state_next = S_07;
            default: state_next = S_18;
          endcase
        end
      end
      S_00:      state_next = BEN ? S_22 : S_18;
      S_04:      state_next = IR_11 ? S_21 : S_20;
      S_06:      state_next = S_25;
      S_25:      if (wait_done) state_next = S_27;
      S_07:      state_next = S_23;
      S_23:      state_next = S_16;
      S_16:      if (wait_done) state_next = S_18;
      // Two pause states make each Continue press advance exactly once.
      PAUSE_IR1: if (Continue) state_next = PAUSE_IR2;
      PAUSE_IR2: if (!Continue) state_next = S_18;
      S_01, S_05, S_09, S_22, S_12, S_21, S_20, S_27: state_next = S_18;
      default:   state_next = HALTED;
    endcase
  end

  // Counter reloads whenever a memory-wait state is entered and counts down to zero.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (is_mem_wait(state_next) && (state_next != state_reg))
      wait_cnt_next = WAIT_LAST;
    else if (is_mem_wait(state_reg) && !wait_done)
      wait_cnt_next = wait_cnt_reg - 3'd1;
  end

  assign SR2MUX = IR_5;

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR  = 1'b0; LD_BEN = 1'b0;
    LD_CC  = 1'b0; LD_REG = 1'b0; LD_PC  = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX  = PCMUX_INC; DRMUX = 1'b0; SR1MUX = 1'b0; ADDR1MUX = 1'b0;
    ADDR2MUX = ADDR2_ZERO; ALUK = ALUK_ADD;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    case (state_reg)
      S_18: begin GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = PCMUX_INC; LD_PC = 1'b1; end
      S_33, S_25: begin Mem_OE = 1'b0; LD_MDR = 1'b1; end
      S_35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_32: LD_BEN = 1'b1;
      S_01, S_05, S_09: begin
        SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        ALUK = (state_reg == S_01) ? ALUK_ADD :
               (state_reg == S_05) ? ALUK_AND : ALUK_NOT;
      end
      S_22: begin ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_12, S_20: begin
        SR1MUX = 1'b1; ALUK = ALUK_PASSA; GateALU = 1'b1; PCMUX = PCMUX_BUS; LD_PC = 1'b1;
      end
      S_04: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S_21: begin ADDR2MUX = ADDR2_OFF11; ADDR1MUX = 1'b0; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_06, S_07: begin ADDR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6; GateMARMUX = 1'b1; LD_MAR = 1'b1; end
      S_27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_23: begin SR1MUX = 1'b0; ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1; end
      S_16: Mem_WE = 1'b0;
      PAUSE_IR1: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu_lc3.sv
// Scoreboard bench for isdu_lc3: each instruction's expected per-cycle control
// words are queued at issue time and compared by an independent monitor.
module tb_isdu_lc3;

  localparam int W = 3;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

  isdu_lc3 #(.MEM_WAIT_CYCLES(W), .OP_PAUSE(4'b1101)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mem_oe, mem_we;
  } ctl_t;

  ctl_t  act;
  ctl_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  int    instr_no = 0;

  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

  function automatic ctl_t idle(input logic ir5);
    ctl_t c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    c.sr2mux = ir5;
    return c;
  endfunction

  task automatic push(input ctl_t c, input string tag);
    exp_q.push_back(c);
    tag_q.push_back(tag);
  endtask

  // Expected control words for one instruction, phrased as the architectural
  // micro-steps an LC-3 instruction goes through.
  task automatic expect_instr(input logic [3:0] op, input logic ir5, ir11, ben,
                              input int h, c_hi, input bit stop_in_ldr_read);
    ctl_t c;
    c = idle(ir5); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; push(c, "fetch_mar");
    for (int i = 0; i < W; i++) begin
      c = idle(ir5); c.mem_oe = 0; c.ld_mdr = 1; push(c, "fetch_read");
    end
    c = idle(ir5); c.gate_mdr = 1; c.ld_ir = 1; push(c, "fetch_ir");
    c = idle(ir5); c.ld_ben = 1; push(c, "decode");
    if (op == 4'b1101) begin
      for (int i = 0; i < h; i++) begin c = idle(ir5); c.ld_led = 1; push(c, "pause_wait"); end
      for (int i = 0; i < c_hi; i++) push(idle(ir5), "pause_release");
    end else begin
      case (op)
        4'b0001, 4'b0101, 4'b1001: begin
          c = idle(ir5); c.sr1mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
          c.aluk = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
          push(c, "alu_op");
        end
        4'b0000: begin
          push(idle(ir5), "br_test");
          if (ben) begin
            c = idle(ir5); c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; push(c, "br_taken");
          end
        end
        4'b1100: begin
          c = idle(ir5); c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1; c.pcmux = 2'b01; c.ld_pc = 1;
          push(c, "jmp");
        end
        4'b0100: begin
          c = idle(ir5); c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; push(c, "jsr_link");
          c = idle(ir5); c.ld_pc = 1;
          if (ir11) begin c.addr2mux = 2'b11; c.pcmux = 2'b10; end
          else begin c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1; c.pcmux = 2'b01; end
          push(c, "jsr_target");
        end
        4'b0110, 4'b0111: begin
          c = idle(ir5); c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1;
          push(c, "ea_mar");
          if (op == 4'b0110) begin
            for (int i = 0; i < (stop_in_ldr_read ? 2 : W); i++) begin
              c = idle(ir5); c.mem_oe = 0; c.ld_mdr = 1; push(c, "ldr_read");
            end
            if (!stop_in_ldr_read) begin
              c = idle(ir5); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; push(c, "ldr_wb");
            end
          end else begin
            c = idle(ir5); c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; push(c, "str_mdr");
            for (int i = 0; i < W; i++) begin c = idle(ir5); c.mem_we = 0; push(c, "str_write"); end
          end
        end
        default: ;
      endcase
    end
  endtask

  // Called at the negedge before the fetch cycle; returns at the negedge of
  // the instruction's last cycle.
  task automatic issue(input logic [3:0] op, input logic ir5, ir11, ben,
                       input int h, c_hi, input bit stop_in_ldr_read);
    int n;
    IR_5 = ir5;
    expect_instr(op, ir5, ir11, ben, h, c_hi, stop_in_ldr_read);
    n = exp_q.size();
    instr_no++;
    $display("instr %0d op=%b ir5=%b ir11=%b ben=%b h=%0d c=%0d cycles=%0d",
             instr_no, op, ir5, ir11, ben, h, c_hi, n);
    for (int j = 0; j < n; j++) begin
      @(negedge Clk);
      if (j == 0) begin
        Opcode = op; IR_11 = ir11; BEN = ben; Continue = 1'b0;
        Run = 1'($urandom_range(0, 1));
      end
      if (op == 4'b1101 && j == W + 3 + h - 1) Continue = 1'b1;
      if (op == 4'b1101 && j == n - 1) Continue = 1'b0;
    end
  endtask

  task automatic issue_random();
    issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 3), 1'b0);
  endtask

  initial begin : monitor
    ctl_t  e;
    string t;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", t, act, e);
        end
      end
    end
  end

  initial begin : stimulus
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0000;
    IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) push(idle(1'b0), "halted_idle");
    repeat (10) @(negedge Clk);

    Run = 1'b1;
    issue(4'b0001, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
    issue(4'b0000, 1'b1, 1'b0, 1'b1, 1, 1, 1'b0);
    issue(4'b0000, 1'b0, 1'b1, 1'b0, 1, 1, 1'b0);
    issue(4'b0111, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0);
    issue(4'b0101, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0);
    issue(4'b1001, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
    issue(4'b1100, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
    issue(4'b0100, 1'b0, 1'b1, 1'b0, 1, 1, 1'b0);
    issue(4'b0100, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0);
    issue(4'b0110, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
    issue(4'b1101, 1'b0, 1'b0, 1'b0, 3, 1, 1'b0);
    issue(4'b1101, 1'b1, 1'b0, 1'b0, 2, 20, 1'b0);
    issue(4'b1111, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
    for (int i = 0; i < 40; i++) issue_random();

    // Reset during the second read cycle of an LDR, then restart from Halted.
    issue(4'b0110, 1'b0, 1'b0, 1'b0, 1, 1, 1'b1);
    Reset = 1'b1; Run = 1'b0;
    push(idle(IR_5), "reset_mid_read");
    @(negedge Clk);
    Reset = 1'b0;
    push(idle(IR_5), "halted_after_reset");
    @(negedge Clk);
    Run = 1'b1;
    issue(4'b0110, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0);
    for (int i = 0; i < 10; i++) issue_random();

    repeat (3) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
